// File: rtl/ysyx_24110015_axi_pkg.sv
// ysyx_24110015_axi_pkg: shared AXI4-lite response codes, FSM states and SRAM base address
package ysyx_24110015_axi_pkg;
    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam logic [31:0] SRAM_BASE = 32'h0f00_0000;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;
endpackage

// File: rtl/ysyx_24110015_axi_sram_if.sv
// axi_lite_if: AXI4-lite bus bundle with master/slave views
interface axi_lite_if;
    import ysyx_24110015_axi_pkg::*;
    logic [31:0] araddr;
    logic [2:0] arsize;
    logic arvalid, arready;
    logic [31:0] rdata;
    resp_t rresp;
    logic rvalid, rready;
    logic [31:0] awaddr;
    logic [2:0] awsize;
    logic awvalid, awready;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic wlast, wvalid, wready;
    resp_t bresp;
    logic bvalid, bready;
    modport master (
        output araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
    modport slave (
        input araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_24110015_axi_sram_lfsr16.sv
// ysyx_24110015_lfsr16: free-running 16-bit Galois LFSR (taps 16,14,13,11) used for random response delays
module ysyx_24110015_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= SEED;
        else q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
endmodule

// File: rtl/ysyx_24110015_axi_sram.sv
// ysyx_24110015_axi_sram: AXI4-lite SRAM model with programmable read/write latency.
// Define YSYX_24110015_AXI_SRAM_RAND_DELAY_EN to add 0..15 LFSR-driven extra cycles per transaction.
module ysyx_24110015_axi_sram
    import ysyx_24110015_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = SRAM_BASE,
    parameter int DEPTH = 2048,
    parameter int RD_LAT = 1,
    parameter int WR_LAT = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic clk,
    input logic rst,
    axi_lite_if.slave axiif
);
    localparam int IW = $clog2(DEPTH);
    logic [31:0] mem [DEPTH];
    rd_state_t rs;
    wr_state_t ws;
    logic [4:0] rcnt, wcnt;
    logic [IW-1:0] ridx, widx;
    logic r_in, w_in;
    logic [31:0] wdata_q;
    logic [3:0] wstrb_q;
    logic [3:0] extra;
    logic [31:0] ar_off, aw_off;
    logic aw_hs, w_hs, aw_got, w_got, commit;
    logic unused_ok;
`ifdef YSYX_24110015_AXI_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr;
    logic unused_lfsr;
    ysyx_24110015_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lfsr));
    assign extra = lfsr[3:0];
    assign unused_lfsr = ^lfsr[15:4];
`else
    assign extra = 4'd0;
`endif
    assign unused_ok = ^{axiif.arsize, axiif.awsize, axiif.wlast, LFSR_SEED};
    // unsigned offset: addresses below the base wrap high and fall out of range
    assign ar_off = axiif.araddr - BASE_ADDR;
    assign aw_off = axiif.awaddr - BASE_ADDR;
    assign aw_hs = axiif.awvalid & axiif.awready;
    assign w_hs = axiif.wvalid & axiif.wready;
    assign aw_got = aw_hs | ~axiif.awready;
    assign w_got = w_hs | ~axiif.wready;
    assign commit = ws == W_WAIT && wcnt == 5'd0 && w_in;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rs <= R_IDLE;
            rcnt <= '0;
            ridx <= '0;
            r_in <= 1'b0;
            axiif.arready <= 1'b1;
            axiif.rvalid <= 1'b0;
            axiif.rdata <= '0;
            axiif.rresp <= RESP_OKAY;
        end else
            case (rs)
                R_IDLE: if (axiif.arvalid) begin
                    rs <= R_WAIT;
                    axiif.arready <= 1'b0;
                    ridx <= ar_off[IW+1:2];
                    r_in <= ar_off < 32'(4 * DEPTH);
                    rcnt <= 5'(RD_LAT - 1) + 5'(extra);
                end
                R_WAIT: if (rcnt == 5'd0) begin
                    rs <= R_RESP;
                    axiif.rvalid <= 1'b1;
                    axiif.rdata <= r_in ? mem[ridx] : 32'd0;
                    axiif.rresp <= r_in ? RESP_OKAY : RESP_SLVERR;
                end else rcnt <= rcnt - 5'd1;
                R_RESP: if (axiif.rready) begin
                    rs <= R_IDLE;
                    axiif.rvalid <= 1'b0;
                    axiif.arready <= 1'b1;
                end
                default: rs <= R_IDLE;
            endcase
    // AW and W ready each drop on their own handshake; both re-open only after B completes
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ws <= W_IDLE;
            wcnt <= '0;
            widx <= '0;
            w_in <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            axiif.awready <= 1'b1;
            axiif.wready <= 1'b1;
            axiif.bvalid <= 1'b0;
            axiif.bresp <= RESP_OKAY;
        end else
            case (ws)
                W_IDLE: begin
                    if (aw_hs) begin
                        axiif.awready <= 1'b0;
                        widx <= aw_off[IW+1:2];
                        w_in <= aw_off < 32'(4 * DEPTH);
                    end
                    if (w_hs) begin
                        axiif.wready <= 1'b0;
                        wdata_q <= axiif.wdata;
                        wstrb_q <= axiif.wstrb;
                    end
                    if (aw_got & w_got) begin
                        ws <= W_WAIT;
                        wcnt <= 5'(WR_LAT - 1) + 5'(extra);
                    end
                end
                W_WAIT: if (wcnt == 5'd0) begin
                    ws <= W_RESP;
                    axiif.bvalid <= 1'b1;
                    axiif.bresp <= w_in ? RESP_OKAY : RESP_SLVERR;
                end else wcnt <= wcnt - 5'd1;
                W_RESP: if (axiif.bready) begin
                    ws <= W_IDLE;
                    axiif.bvalid <= 1'b0;
                    axiif.awready <= 1'b1;
                    axiif.wready <= 1'b1;
                end
                default: ws <= W_IDLE;
            endcase
    always_ff @(posedge clk)
        if (commit)
            for (int i = 0; i < 4; i++)
                if (wstrb_q[i]) mem[widx][8*i +: 8] <= wdata_q[8*i +: 8];
endmodule

// File: tb/tb_ysyx_24110015_axi_sram.sv
// tb_ysyx_24110015_axi_sram: randomized and directed AXI4-lite traffic against a word-map model of the SRAM
module tb_ysyx_24110015_axi_sram;
    localparam logic [31:0] BASE = 32'h0f00_0000;
    localparam int DEPTH = 2048;
    localparam int RL = 2;
    localparam int WL = 3;
    typedef struct {logic [31:0] d; logic [1:0] r; int due;} rexp_t;
    typedef struct {logic [1:0] r; int due;} bexp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit prv = 1'b0;
    bit pbv = 1'b0;
    rexp_t exp_r[$];
    bexp_t exp_b[$];
    logic [31:0] mdl [int];
    axi_lite_if axi();
    ysyx_24110015_axi_sram #(
        .BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LAT(RL), .WR_LAT(WL), .LFSR_SEED(16'hACE1)
    ) dut (.clk(clk), .rst(rst), .axiif(axi));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask
    function automatic bit in_rng(input logic [31:0] a);
        longint la = longint'(a);
        return la >= longint'(BASE) && la < longint'(BASE) + 4 * DEPTH;
    endfunction
    function automatic int widx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction
    function automatic void model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        d = 32'd0;
        r = 2'b10;
        if (in_rng(a)) begin
            d = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'd0;
            r = 2'b00;
        end
    endfunction
    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (!in_rng(a)) return 2'b10;
        w = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'd0;
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        mdl[widx(a)] = w;
        return 2'b00;
    endfunction
    // single compare process: every response cycle is checked against the model's queued expectations
    always @(negedge clk) begin
        if (!rst) begin
            if (axi.rvalid) begin
                if (exp_r.size() == 0) chk("r_unexpected", 64'(axi.rvalid), 64'(0));
                else begin
                    chk("rdata", 64'(axi.rdata), 64'(exp_r[0].d));
                    chk("rresp", 64'(axi.rresp), 64'(exp_r[0].r));
                    chk("ar_busy", 64'(axi.arready), 64'(0));
                    if (!prv) chk("r_latency", 64'(cyc), 64'(exp_r[0].due));
                    if (axi.rready) void'(exp_r.pop_front());
                end
            end
            if (axi.bvalid) begin
                if (exp_b.size() == 0) chk("b_unexpected", 64'(axi.bvalid), 64'(0));
                else begin
                    chk("bresp", 64'(axi.bresp), 64'(exp_b[0].r));
                    chk("aw_busy", 64'({axi.awready, axi.wready}), 64'(0));
                    if (!pbv) chk("b_latency", 64'(cyc), 64'(exp_b[0].due));
                    if (axi.bready) void'(exp_b.pop_front());
                end
            end
        end
        prv = axi.rvalid;
        pbv = axi.bvalid;
    end
    task automatic check_idle(input string tag);
        chk({tag, "_arready"}, 64'(axi.arready), 64'(1));
        chk({tag, "_awready"}, 64'(axi.awready), 64'(1));
        chk({tag, "_wready"}, 64'(axi.wready), 64'(1));
        chk({tag, "_rvalid"}, 64'(axi.rvalid), 64'(0));
        chk({tag, "_bvalid"}, 64'(axi.bvalid), 64'(0));
        chk({tag, "_rdata"}, 64'(axi.rdata), 64'(0));
        chk({tag, "_rresp"}, 64'(axi.rresp), 64'(0));
        chk({tag, "_bresp"}, 64'(axi.bresp), 64'(0));
    endtask
    task automatic do_read(input logic [31:0] a, input int rdly);
        int n;
        bit h;
        rexp_t e;
        @(posedge clk); #1;
        axi.araddr = a;
        axi.arsize = 3'd2;
        axi.arvalid = 1'b1;
        n = 0;
        h = 1'b0;
        while (!h && n < 50) begin
            @(negedge clk);
            h = axi.arvalid && axi.arready;
            @(posedge clk); #1;
            n++;
        end
        axi.arvalid = 1'b0;
        chk("ar_timeout", 64'(h), 64'(1));
        if (h) begin
            model_read(a, e.d, e.r);
            e.due = cyc + RL;
            exp_r.push_back(e);
            n = 0;
            while (!axi.rvalid && n < 100) begin @(posedge clk); #1; n++; end
            chk("r_timeout", 64'(n < 100), 64'(1));
            repeat (rdly) begin @(posedge clk); #1; end
            axi.rready = 1'b1;
            @(posedge clk); #1;
            axi.rready = 1'b0;
        end
    endtask
    // wlead > 0: W is presented wlead cycles before AW; wlead < 0: AW leads
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int wlead, input int bdly, input bit abort);
        int aw_start, w_start, n;
        bit aw_done, w_done, haw, hw;
        bexp_t e;
        aw_start = wlead > 0 ? wlead : 0;
        w_start = wlead < 0 ? -wlead : 0;
        aw_done = 1'b0;
        w_done = 1'b0;
        n = 0;
        @(posedge clk); #1;
        axi.awaddr = a;
        axi.awsize = 3'd2;
        axi.wdata = d;
        axi.wstrb = s;
        axi.wlast = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            axi.awvalid = !aw_done && n >= aw_start;
            axi.wvalid = !w_done && n >= w_start;
            @(negedge clk);
            haw = axi.awvalid && axi.awready;
            hw = axi.wvalid && axi.wready;
            if (w_done && !aw_done) chk("w_taken_wready", 64'(axi.wready), 64'(0));
            if (aw_done && !w_done) chk("aw_taken_awready", 64'(axi.awready), 64'(0));
            @(posedge clk); #1;
            aw_done |= haw;
            w_done |= hw;
            n++;
        end
        axi.awvalid = 1'b0;
        axi.wvalid = 1'b0;
        chk("aw_w_timeout", 64'(aw_done && w_done), 64'(1));
        if (aw_done && w_done) begin
            if (abort) begin
                @(posedge clk); #1;
                rst = 1'b1;
                repeat (2) begin @(posedge clk); #1; end
                rst = 1'b0;
                #1;
                check_idle("abort");
                repeat (WL + 3) begin
                    @(negedge clk);
                    chk("abort_bvalid", 64'(axi.bvalid), 64'(0));
                end
            end else begin
                e.r = model_write(a, d, s);
                e.due = cyc + WL;
                exp_b.push_back(e);
                n = 0;
                while (!axi.bvalid && n < 100) begin @(posedge clk); #1; n++; end
                chk("b_timeout", 64'(n < 100), 64'(1));
                repeat (bdly) begin @(posedge clk); #1; end
                axi.bready = 1'b1;
                @(posedge clk); #1;
                axi.bready = 1'b0;
            end
        end
    endtask
    initial begin
        logic [31:0] a, d;
        logic [1:0] r;
        int k;
        axi.araddr = '0; axi.arsize = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        axi.awaddr = '0; axi.awsize = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        for (int i = 0; i < 16; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 1'b0);
        do_write(32'h0f00_0004, 32'hdeadbeef, 4'hF, 0, 0, 1'b0);
        chk("pin_full_word", 64'(mdl[1]), 64'h0000_0000_dead_beef);
        do_read(32'h0f00_0004, 0);
        do_write(32'h0f00_0004, 32'h00aa_0000, 4'b0100, 0, 1, 1'b0);
        chk("pin_byte_lane", 64'(mdl[1]), 64'h0000_0000_deaa_beef);
        do_read(32'h0f00_0004, 0);
        do_write(32'h0f00_0010, 32'h1357_9bdf, 4'hF, 3, 0, 1'b0);
        do_read(32'h0f00_0010, 1);
        model_read(32'h0f00_2000, d, r);
        chk("pin_rd_oor", 64'({d, r}), 64'({32'h0, 2'b10}));
        do_read(32'h0f00_2000, 0);
        r = model_write(32'h0e00_0000, 32'hffff_ffff, 4'hF);
        chk("pin_wr_oor", 64'(r), 64'(2'b10));
        do_write(32'h0e00_0000, 32'hffff_ffff, 4'hF, -2, 0, 1'b0);
        do_read(32'h0f00_0000, 0);
        do_read(32'h0f00_0004, 5);
        do_write(32'h0f00_0008, 32'h1234_5678, 4'hF, 0, 0, 1'b1);
        do_read(32'h0f00_0008, 0);
        for (int i = 0; i < 80; i++) begin
            k = int'($urandom_range(0, 7));
            a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if (k == 0) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            if (k == 1 && $urandom_range(0, 1) == 1) a = BASE - 32'(4 * $urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                         int'($urandom_range(0, 3)), 1'b0);
            else do_read(a, int'($urandom_range(0, 4)));
        end
        repeat (10) @(posedge clk);
        #1;
        chk("r_queue_drained", 64'(exp_r.size()), 64'(0));
        chk("b_queue_drained", 64'(exp_b.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
